// File: rtl/c7bexu_mem_arb_pkg.sv
// Shared types, widths and default parameters for the c7bexu memory-bus arbiter.
package c7bexu_mem_arb_pkg;

    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned STRB_W         = DATA_W / 8;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned TMO_CYC_DEF    = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } arb_owner_e;

    // Captured request payload that drives the memory bus.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } bus_cmd_t;

    // Counter width able to hold 0..max_val (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/c7bexu_mem_arb_tmo.sv
// Response-timeout counter for the memory-bus arbiter; instantiated only when
// C7BEXU_MEM_ARB_TMO_EN is defined.
module c7bexu_mem_arb_tmo
    import c7bexu_mem_arb_pkg::*;
#(
    parameter int unsigned TMO_CYC = TMO_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_active,
    output logic o_expire_c
);

    localparam int unsigned CW = cnt_width(TMO_CYC);

    logic [CW-1:0] r_cnt;

    // Counts cycles spent waiting; the final count is held until restarted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_start) begin
            r_cnt <= '0;
        end else if (i_active && (r_cnt != CW'(TMO_CYC - 1))) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expire_c = i_active && (r_cnt == CW'(TMO_CYC - 1));

endmodule

// File: rtl/c7bexu_mem_arb.sv
// Shares the single memory bus between instruction fetch and the LSU.
// Optional response timeout is compiled in with C7BEXU_MEM_ARB_TMO_EN.
module c7bexu_mem_arb
    import c7bexu_mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
    parameter int unsigned TMO_CYC    = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_err,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    output logic              lsu_gnt,
    output logic              lsu_data_valid,
    output logic              lsu_wr_fin,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_buserr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [STRB_W-1:0] bus_wstrb,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_err
);

    localparam int unsigned SC_W = cnt_width(STARVE_MAX);

    if (STARVE_MAX < 1) begin : g_bad_starve
        $error("c7bexu_mem_arb: STARVE_MAX must be at least 1");
    end
    if (TMO_CYC < 1) begin : g_bad_tmo
        $error("c7bexu_mem_arb: TMO_CYC must be at least 1");
    end

    arb_state_e        r_state;
    arb_owner_e        r_owner;
    bus_cmd_t          r_cmd;
    logic [SC_W-1:0]   r_starve_cnt;
    logic              r_ifu_rvalid;
    logic              r_lsu_data_valid;
    logic              r_lsu_wr_fin;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_idle;
    logic              w_starved;
    logic              w_ifu_win;
    logic              w_ifu_gnt;
    logic              w_lsu_gnt;
    logic              w_tmo_expire;
    logic              w_resp_done;
    logic [DATA_W-1:0] w_resp_data;
    logic              w_resp_err;

    // LSU has priority unless IFU has been passed over STARVE_MAX times.
    assign w_idle    = (r_state == ST_IDLE);
    assign w_starved = (r_starve_cnt == SC_W'(STARVE_MAX));
    assign w_ifu_win = ifu_req && (!lsu_req || w_starved);
    assign w_ifu_gnt = !reset && w_idle && w_ifu_win;
    assign w_lsu_gnt = !reset && w_idle && lsu_req && !w_ifu_win;

`ifdef C7BEXU_MEM_ARB_TMO_EN
    logic w_tmo_start;
    logic w_tmo_active;

    assign w_tmo_start  = (r_state == ST_REQ) && bus_gnt;
    assign w_tmo_active = (r_state == ST_RESP);

    c7bexu_mem_arb_tmo #(
        .TMO_CYC   (TMO_CYC)
    ) u_tmo (
        .clk       (clk),
        .reset     (reset),
        .i_start   (w_tmo_start),
        .i_active  (w_tmo_active),
        .o_expire_c(w_tmo_expire)
    );
`else
    assign w_tmo_expire = 1'b0;
`endif

    // A real response wins over a coinciding timeout.
    assign w_resp_done = (r_state == ST_RESP) && (bus_rvalid || w_tmo_expire);
    assign w_resp_data = bus_rvalid ? bus_rdata : '0;
    assign w_resp_err  = bus_rvalid ? bus_err : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_owner          <= OWN_IFU;
            r_cmd            <= '0;
            r_starve_cnt     <= '0;
            r_ifu_rvalid     <= 1'b0;
            r_lsu_data_valid <= 1'b0;
            r_lsu_wr_fin     <= 1'b0;
            r_rdata          <= '0;
            r_err            <= 1'b0;
        end else begin
            r_ifu_rvalid     <= 1'b0;
            r_lsu_data_valid <= 1'b0;
            r_lsu_wr_fin     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ifu_gnt) begin
                        r_state      <= ST_REQ;
                        r_owner      <= OWN_IFU;
                        r_cmd        <= '{we: 1'b0, addr: ifu_addr, wdata: '0, wstrb: '0};
                        r_starve_cnt <= '0;
                    end else if (w_lsu_gnt) begin
                        r_state <= ST_REQ;
                        r_owner <= OWN_LSU;
                        r_cmd   <= '{we: lsu_we, addr: lsu_addr, wdata: lsu_wdata, wstrb: lsu_wstrb};
                        if (ifu_req && !w_starved) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_gnt) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_resp_done) begin
                        r_state          <= ST_IDLE;
                        r_ifu_rvalid     <= (r_owner == OWN_IFU);
                        r_lsu_data_valid <= (r_owner == OWN_LSU) && !r_cmd.we;
                        r_lsu_wr_fin     <= (r_owner == OWN_LSU) && r_cmd.we;
                        r_rdata          <= w_resp_data;
                        r_err            <= w_resp_err;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ifu_gnt        = w_ifu_gnt;
    assign lsu_gnt        = w_lsu_gnt;
    assign bus_req        = (r_state == ST_REQ);
    assign bus_we         = r_cmd.we;
    assign bus_addr       = r_cmd.addr;
    assign bus_wdata      = r_cmd.wdata;
    assign bus_wstrb      = r_cmd.wstrb;
    assign ifu_rvalid     = r_ifu_rvalid;
    assign ifu_rdata      = r_rdata;
    assign ifu_err        = r_err;
    assign lsu_data_valid = r_lsu_data_valid;
    assign lsu_wr_fin     = r_lsu_wr_fin;
    assign lsu_rdata      = r_rdata;
    assign lsu_buserr     = r_err;

endmodule

// File: tb/tb_c7bexu_mem_arb.sv
// Self-checking bench for c7bexu_mem_arb: transaction-level model plus directed
// and randomized traffic. Define C7BEXU_MEM_ARB_TMO_EN to also cover the timeout.
module tb_c7bexu_mem_arb;

    localparam int unsigned SM = 4;
`ifdef C7BEXU_MEM_ARB_TMO_EN
    localparam int unsigned TMO = 8;
`else
    localparam int unsigned TMO = 255;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_gnt, ifu_rvalid, ifu_err;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_gnt, lsu_data_valid, lsu_wr_fin, lsu_buserr;
    logic [31:0] lsu_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    always #5 clk = ~clk;

    c7bexu_mem_arb #(
        .STARVE_MAX    (SM),
        .TMO_CYC       (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ifu_req       (ifu_req),
        .ifu_addr      (ifu_addr),
        .ifu_gnt       (ifu_gnt),
        .ifu_rvalid    (ifu_rvalid),
        .ifu_rdata     (ifu_rdata),
        .ifu_err       (ifu_err),
        .lsu_req       (lsu_req),
        .lsu_we        (lsu_we),
        .lsu_addr      (lsu_addr),
        .lsu_wdata     (lsu_wdata),
        .lsu_wstrb     (lsu_wstrb),
        .lsu_gnt       (lsu_gnt),
        .lsu_data_valid(lsu_data_valid),
        .lsu_wr_fin    (lsu_wr_fin),
        .lsu_rdata     (lsu_rdata),
        .lsu_buserr    (lsu_buserr),
        .bus_req       (bus_req),
        .bus_we        (bus_we),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_wstrb     (bus_wstrb),
        .bus_gnt       (bus_gnt),
        .bus_rvalid    (bus_rvalid),
        .bus_rdata     (bus_rdata),
        .bus_err       (bus_err)
    );

    int n_chk = 0;
    int n_err = 0;

    // Transaction-level model: one outstanding transfer, plus the pending completion.
    bit          m_busy = 1'b0;      // a transfer owns the bus
    bit          m_acc = 1'b0;       // the bus has accepted it
    int          m_starve = 0;
    int          m_wait = 0;
    bit          m_own_lsu = 1'b0;
    bit          m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_strb = '0;
    int          m_stb = 0;          // 0 none, 1 IFU, 2 LSU load, 3 LSU store
    logic [31:0] m_rdata = '0;
    bit          m_err = 1'b0;
    bit          m_last_gi = 1'b0;
    bit          m_last_gl = 1'b0;
    int          gnt_log[$];
    int          pat[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ifu_req    = 1'b0;
        lsu_req    = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
    endtask

    // Ideal bus: accepts immediately, answers the cycle after acceptance.
    task automatic auto_bus();
        bus_gnt    = m_busy && !m_acc;
        bus_rvalid = m_busy && m_acc;
        bus_rdata  = $urandom;
        bus_err    = 1'b0;
    endtask

    task automatic complete(input logic [31:0] d, input bit e);
        m_stb   = !m_own_lsu ? 1 : (m_we ? 3 : 2);
        m_rdata = d;
        m_err   = e;
        m_busy  = 1'b0;
        m_acc   = 1'b0;
    endtask

    // Compare all outputs for this cycle, then advance the model by one clock.
    task automatic sample();
        bit ifu_win, eg_i, eg_l, ereq;
        int stb;
        @(negedge clk);
        ifu_win = ifu_req && (!lsu_req || (m_starve == SM));
        eg_i    = !reset && !m_busy && ifu_win;
        eg_l    = !reset && !m_busy && lsu_req && !ifu_win;
        ereq    = !reset && m_busy && !m_acc;
        stb     = reset ? 0 : m_stb;
        chk("ifu_gnt", 32'(ifu_gnt), 32'(eg_i));
        chk("lsu_gnt", 32'(lsu_gnt), 32'(eg_l));
        chk("bus_req", 32'(bus_req), 32'(ereq));
        chk("ifu_rvalid", 32'(ifu_rvalid), 32'(stb == 1));
        chk("lsu_data_valid", 32'(lsu_data_valid), 32'(stb == 2));
        chk("lsu_wr_fin", 32'(lsu_wr_fin), 32'(stb == 3));
        if (ereq) begin
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_we", 32'(bus_we), 32'(m_we));
            chk("bus_wstrb", 32'(bus_wstrb), 32'(m_strb));
            if (m_we) chk("bus_wdata", bus_wdata, m_wdata);
        end
        if (stb == 1) begin
            chk("ifu_rdata", ifu_rdata, m_rdata);
            chk("ifu_err", 32'(ifu_err), 32'(m_err));
        end
        if (stb >= 2) begin
            chk("lsu_rdata", lsu_rdata, m_rdata);
            chk("lsu_buserr", 32'(lsu_buserr), 32'(m_err));
        end
        if (reset) begin
            chk("rst_bus_addr", bus_addr, 32'd0);
            chk("rst_bus_wdata", bus_wdata, 32'd0);
            chk("rst_bus_misc", {27'd0, bus_we, bus_wstrb}, 32'd0);
            chk("rst_rdata", ifu_rdata | lsu_rdata, 32'd0);
            chk("rst_err", 32'(ifu_err | lsu_buserr), 32'd0);
        end
        if (ifu_gnt) gnt_log.push_back(0);
        if (lsu_gnt) gnt_log.push_back(1);
        m_last_gi = eg_i;
        m_last_gl = eg_l;
        if (reset) begin
            m_busy   = 1'b0;
            m_acc    = 1'b0;
            m_starve = 0;
            m_stb    = 0;
        end else begin
            m_stb = 0;
            if (m_busy && m_acc) begin
                if (bus_rvalid) begin
                    complete(bus_rdata, bus_err);
                end else begin
`ifdef C7BEXU_MEM_ARB_TMO_EN
                    if (m_wait == TMO - 1) complete(32'd0, 1'b1);
                    else m_wait++;
`endif
                end
            end else if (m_busy) begin
                if (bus_gnt) begin
                    m_acc  = 1'b1;
                    m_wait = 0;
                end
            end else if (eg_i || eg_l) begin
                m_busy    = 1'b1;
                m_acc     = 1'b0;
                m_own_lsu = eg_l;
                m_we      = eg_l && lsu_we;
                m_addr    = eg_l ? lsu_addr : ifu_addr;
                m_wdata   = lsu_wdata;
                m_strb    = eg_l ? lsu_wstrb : 4'd0;
                if (eg_i) m_starve = 0;
                else if (ifu_req) m_starve = (m_starve < SM) ? m_starve + 1 : SM;
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 10 && m_busy; c++) begin
            drive_edge();
            quiet();
            auto_bus();
            sample();
        end
        drive_edge();
        quiet();
        sample();
        chk("drain_idle", 32'(m_busy), 32'd0);
    endtask

    task automatic ifu_fetch(input logic [31:0] a, input logic [31:0] d);
        drive_edge(); quiet(); ifu_req = 1'b1; ifu_addr = a;
        sample();
        chk("fetch_gnt", 32'(ifu_gnt), 32'd1);
        drive_edge(); ifu_req = 1'b0; bus_gnt = 1'b1;
        sample();
        chk("fetch_bus_req", 32'(bus_req), 32'd1);
        chk("fetch_addr", bus_addr, a);
        chk("fetch_we_strb", {27'd0, bus_we, bus_wstrb}, 32'd0);
        drive_edge(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = d; bus_err = 1'b0;
        sample();
        chk("fetch_early", 32'(ifu_rvalid), 32'd0);
        drive_edge(); bus_rvalid = 1'b0;
        sample();
        chk("fetch_rvalid", 32'(ifu_rvalid), 32'd1);
        chk("fetch_rdata", ifu_rdata, d);
        chk("fetch_err", 32'(ifu_err), 32'd0);
    endtask

    task automatic lsu_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic [31:0] rd, input logic er);
        drive_edge(); quiet();
        lsu_req = 1'b1; lsu_we = we; lsu_addr = a; lsu_wdata = wd; lsu_wstrb = st;
        sample();
        chk("lsu_op_gnt", {30'd0, lsu_gnt, ifu_gnt}, 32'd2);
        drive_edge(); lsu_req = 1'b0;
        sample();
        chk("lsu_op_bus_req", 32'(bus_req), 32'd1);
        chk("lsu_op_we", 32'(bus_we), 32'(we));
        chk("lsu_op_strb", 32'(bus_wstrb), 32'(st));
        chk("lsu_op_addr", bus_addr, a);
        drive_edge(); bus_gnt = 1'b1;
        sample();
        drive_edge(); bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rd; bus_err = er;
        sample();
        drive_edge(); bus_rvalid = 1'b0; bus_err = 1'b0;
        sample();
        chk("lsu_op_strobes", {29'd0, ifu_rvalid, lsu_data_valid, lsu_wr_fin},
            we ? 32'd1 : 32'd2);
        chk("lsu_op_buserr", 32'(lsu_buserr), 32'(er));
        if (!we) chk("lsu_op_rdata", lsu_rdata, rd);
    endtask

    task automatic rand_drive();
        if (!ifu_req || m_last_gi) begin
            ifu_req  = ($urandom_range(0, 2) != 0);
            ifu_addr = $urandom;
        end
        if (!lsu_req || m_last_gl) begin
            lsu_req   = ($urandom_range(0, 2) != 0);
            lsu_we    = ($urandom_range(0, 1) == 1);
            lsu_addr  = $urandom;
            lsu_wdata = $urandom;
            lsu_wstrb = 4'($urandom);
        end
        bus_gnt    = (m_busy && !m_acc) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
        bus_rvalid = (m_busy && m_acc) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        bus_rdata  = $urandom;
        bus_err    = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        repeat (2) begin
            drive_edge();
            sample();
        end
        drive_edge(); reset = 1'b0;
        sample();

        // Both requesters held: LSU wins until IFU has waited STARVE_MAX grants.
        gnt_log.delete();
        drive_edge();
        ifu_req = 1'b1; ifu_addr = 32'h0000_0100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0000_0800;
        auto_bus();
        sample();
        for (int c = 0; c < 60 && gnt_log.size() < 10; c++) begin
            drive_edge();
            auto_bus();
            sample();
        end
        chk("grant_count", 32'((gnt_log.size() >= 10) ? 10 : gnt_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < gnt_log.size()) chk("grant_order", 32'(gnt_log[i]), 32'(pat[i]));
        end
        drain();

        ifu_fetch(32'h0000_1000, 32'hDEAD_BEEF);
        lsu_op(1'b1, 32'h0000_2000, 32'hCAFE_0001, 4'b0011, 32'h1111_2222, 1'b0);
        lsu_op(1'b0, 32'h0000_2400, 32'h0, 4'b0000, 32'h1234_5678, 1'b1);

        // Reset while waiting for the response drops the transfer silently.
        drive_edge(); quiet(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0000_3000;
        sample();
        drive_edge(); lsu_req = 1'b0; bus_gnt = 1'b1;
        sample();
        drive_edge(); bus_gnt = 1'b0; reset = 1'b1;
        sample();
        chk("rst_mid_bus_req", 32'(bus_req), 32'd0);
        drive_edge(); bus_rvalid = 1'b1; bus_rdata = 32'h55AA_55AA;
        sample();
        drive_edge(); reset = 1'b0;
        sample();
        drive_edge(); bus_rvalid = 1'b0;
        sample();
        chk("rst_no_strobe", {29'd0, ifu_rvalid, lsu_data_valid, lsu_wr_fin}, 32'd0);
        ifu_fetch(32'h0000_4000, 32'h0BAD_F00D);

`ifdef C7BEXU_MEM_ARB_TMO_EN
        // No response: error completion TMO cycles after the bus accepted.
        drive_edge(); quiet(); lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0000_5000;
        sample();
        drive_edge(); lsu_req = 1'b0; bus_gnt = 1'b1;
        sample();
        drive_edge(); bus_gnt = 1'b0;
        sample();
        for (int k = 1; k < 9; k++) begin
            drive_edge();
            sample();
            chk("tmo_strobe", 32'(lsu_data_valid), 32'(k == 8));
            if (k == 8) begin
                chk("tmo_err", 32'(lsu_buserr), 32'd1);
                chk("tmo_rdata", lsu_rdata, 32'd0);
            end
        end
        drive_edge(); bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
        sample();
        drive_edge(); bus_rvalid = 1'b0;
        sample();
        chk("tmo_late_ignored", {29'd0, ifu_rvalid, lsu_data_valid, lsu_wr_fin}, 32'd0);
`endif

        for (int c = 0; c < 3000; c++) begin
            drive_edge();
            rand_drive();
            sample();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
